// File: rtl/watcher_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// watcher_capture_ctrl_if
// Buffer read port plus sample output stream of the watcher capture sequencer.
//   rd_en / rd_addr : buffer read strobe and address (sequencer -> RAM)
//   rd_data         : buffer read data, valid one cycle after rd_en (RAM -> seq)
//   smp_valid/data  : sample stream towards the readout path (sequencer -> sink)
//   smp_ready       : sink accepts the current sample (sink -> sequencer)
// master = sequencer side, slave = RAM / readout side.
// -----------------------------------------------------------------------------
interface watcher_capture_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 13
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              smp_valid;
  logic [DATA_W-1:0] smp_data;
  logic              smp_ready;

  modport master (
    output rd_en, rd_addr, smp_valid, smp_data,
    input  rd_data, smp_ready
  );

  modport slave (
    input  rd_en, rd_addr, smp_valid, smp_data,
    output rd_data, smp_ready
  );

endinterface

// File: rtl/watcher_capture_ctrl.sv
// -----------------------------------------------------------------------------
// watcher_capture_ctrl
// Capture sequencer for one watcher trigger node and its sample buffer.
// Clears and arms the trigger node, freezes it on stop, then reads the captured
// window out of the buffer oldest-first onto a valid/ready stream.
// Ports:
//   trig_clk, trig_rstn : clock, synchronous active-low reset
//   arm, abort          : one-cycle control requests (abort wins)
//   cap_len             : samples to read out, 0 or >DEPTH means DEPTH
//   stop_flag/stop_addr : trigger node stop indication and last written address
//   overflow_flag       : trigger node overflow indication
//   node_rstn, pause    : clear and write-freeze to the trigger node
//   state               : 0 IDLE, 1 CLEAR/ARMED, 2 READOUT, 3 DONE
//   ovf_seen            : sticky overflow seen during the current capture
//   bus                 : buffer read port and sample stream (master side)
// -----------------------------------------------------------------------------
module watcher_capture_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 13
) (
  input  logic                    trig_clk,
  input  logic                    trig_rstn,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [ADDR_W:0]         cap_len,
  input  logic                    stop_flag,
  input  logic [ADDR_W-1:0]       stop_addr,
  input  logic                    overflow_flag,
  output logic                    node_rstn,
  output logic                    pause,
  output logic [1:0]              state,
  output logic                    ovf_seen,
  watcher_capture_ctrl_if.master  bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARMED,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } st_t;

  st_t               st;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  eff_len;
  logic [ADDR_W-1:0] start_addr;

  // Effective readout length and oldest sample address of the window.
  // Only the low ADDR_W bits of the length matter for the modulo subtraction,
  // so a full-depth window starts right after the stop address.
  always_comb begin
    eff_len = cap_len;
    if (cap_len == '0 || cap_len > LEN_W'(DEPTH)) begin
      eff_len = LEN_W'(DEPTH);
    end
    start_addr = stop_addr + ADDR_W'(1) - eff_len[ADDR_W-1:0];
  end

  // Sequencer: node control, readout substates and registered outputs.
  always_ff @(posedge trig_clk) begin
    if (!trig_rstn) begin
      st            <= S_IDLE;
      state         <= 2'd0;
      node_rstn     <= 1'b0;
      pause         <= 1'b1;
      ovf_seen      <= 1'b0;
      remaining     <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.smp_valid <= 1'b0;
      bus.smp_data  <= '0;
    end else if (abort) begin
      st            <= S_IDLE;
      state         <= 2'd0;
      node_rstn     <= 1'b1;
      pause         <= 1'b1;
      bus.rd_en     <= 1'b0;
      bus.smp_valid <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          node_rstn <= 1'b1;
          pause     <= 1'b1;
          if (arm) begin
            st        <= S_CLEAR;
            state     <= 2'd1;
            node_rstn <= 1'b0;
            ovf_seen  <= 1'b0;
          end
        end

        S_CLEAR: begin
          st        <= S_ARMED;
          state     <= 2'd1;
          node_rstn <= 1'b1;
          pause     <= 1'b0;
        end

        S_ARMED: begin
          ovf_seen <= ovf_seen | overflow_flag;
          if (stop_flag) begin
            st          <= S_ISSUE;
            state       <= 2'd2;
            pause       <= 1'b1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= start_addr;
            remaining   <= eff_len;
          end
        end

        S_ISSUE: begin
          bus.rd_en <= 1'b0;
          st        <= S_WAIT;
        end

        // RAM data for the issued address is valid in this cycle.
        S_WAIT: begin
          bus.smp_data  <= bus.rd_data;
          bus.smp_valid <= 1'b1;
          st            <= S_HOLD;
        end

        S_HOLD: begin
          if (bus.smp_ready) begin
            bus.smp_valid <= 1'b0;
            remaining     <= remaining - LEN_W'(1);
            bus.rd_addr   <= bus.rd_addr + ADDR_W'(1);
            if (remaining == LEN_W'(1)) begin
              st    <= S_DONE;
              state <= 2'd3;
            end else begin
              st        <= S_ISSUE;
              bus.rd_en <= 1'b1;
            end
          end
        end

        default: begin
          st    <= S_IDLE;
          state <= 2'd0;
        end
      endcase
    end
  end

endmodule
